// File: rtl/agu_arb_pkg.sv
// Shared types for the AGU share arbiter: FSM states, owner ids, access sizes.
// Misalignment helper is used only when AGU_ARB_MISALIGN_CHECK_EN is defined.
package agu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_RESP    = 2'd2
  } state_e;

  typedef enum logic {
    OWN_BR = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic logic misaligned(
    input logic [1:0] sz,
    input logic [1:0] lsb
  );
    logic m;
    m = 1'b0;
    case (sz)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = lsb[0];
      SZ_WORD: m = |lsb;
      default: m = |lsb;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/agu_rr_picker.sv
// Two-way grant picker: round-robin on the last owner, or fixed BR-first.
// Grant is one-hot {ls, br}; zero when nobody is requesting.
module agu_rr_picker
  import agu_arb_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic       br_valid,
  input  logic       ls_valid,
  input  owner_e     last_owner,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (br_valid && ls_valid): begin
        if (FIXED_PRIORITY != 0 || last_owner == OWN_LS) gnt = 2'b01;
        else gnt = 2'b10;
      end
      (br_valid && !ls_valid): gnt = 2'b01;
      (!br_valid && ls_valid): gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/agu_share_arbiter.sv
// Time-shares one address adder between the BR and LS units, one op at a time.
// Define AGU_ARB_MISALIGN_CHECK_EN to add the ls_rsp_misaligned result flag.
module agu_share_arbiter
  import agu_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  br_req_valid,
  output logic                  br_req_ready,
  input  logic [ADDR_WIDTH-1:0] br_pc,
  input  logic [ADDR_WIDTH-1:0] br_imm,
  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic [ADDR_WIDTH-1:0] ls_base,
  input  logic [ADDR_WIDTH-1:0] ls_imm,
  input  logic [1:0]            ls_size,
  output logic [ADDR_WIDTH-1:0] agu_pc,
  output logic [ADDR_WIDTH-1:0] agu_immediate,
  input  logic [ADDR_WIDTH-1:0] agu_address,
  output logic                  br_rsp_valid,
  input  logic                  br_rsp_ready,
  output logic [ADDR_WIDTH-1:0] br_rsp_address,
  output logic                  ls_rsp_valid,
  input  logic                  ls_rsp_ready,
  output logic [ADDR_WIDTH-1:0] ls_rsp_address
`ifdef AGU_ARB_MISALIGN_CHECK_EN
  ,
  output logic                  ls_rsp_misaligned
`endif
);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                last_q, last_d;
  logic [ADDR_WIDTH-1:0] opa_q, opa_d;
  logic [ADDR_WIDTH-1:0] opb_q, opb_d;
  logic [ADDR_WIDTH-1:0] res_q, res_d;
  logic [1:0]            gnt;
  logic                  rsp_ack;

`ifdef AGU_ARB_MISALIGN_CHECK_EN
  logic [1:0] size_q, size_d;
  logic       mis_q, mis_d;
`else
  logic       unused_size;
  assign unused_size = ^ls_size;
`endif

  agu_rr_picker #(
    .FIXED_PRIORITY(FIXED_PRIORITY)
  ) u_picker (
    .br_valid  (br_req_valid),
    .ls_valid  (ls_req_valid),
    .last_owner(last_q),
    .gnt       (gnt)
  );

  assign br_req_ready = (state_q == ST_IDLE) && gnt[0];
  assign ls_req_ready = (state_q == ST_IDLE) && gnt[1];

  // Operands stay parked on the registers so the adder never sees raw inputs
  assign agu_pc        = opa_q;
  assign agu_immediate = opb_q;

  assign br_rsp_valid   = (state_q == ST_RESP) && (owner_q == OWN_BR);
  assign ls_rsp_valid   = (state_q == ST_RESP) && (owner_q == OWN_LS);
  assign br_rsp_address = res_q;
  assign ls_rsp_address = res_q;

  assign rsp_ack = (owner_q == OWN_BR) ? br_rsp_ready : ls_rsp_ready;

`ifdef AGU_ARB_MISALIGN_CHECK_EN
  assign ls_rsp_misaligned = mis_q;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
`ifdef AGU_ARB_MISALIGN_CHECK_EN
    size_d  = size_q;
    mis_d   = mis_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (br_req_ready) begin
          opa_d   = br_pc;
          opb_d   = br_imm;
          owner_d = OWN_BR;
          last_d  = OWN_BR;
          state_d = ST_COMPUTE;
        end else if (ls_req_ready) begin
          opa_d   = ls_base;
          opb_d   = ls_imm;
          owner_d = OWN_LS;
          last_d  = OWN_LS;
`ifdef AGU_ARB_MISALIGN_CHECK_EN
          size_d  = ls_size;
`endif
          state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        res_d   = agu_address;
`ifdef AGU_ARB_MISALIGN_CHECK_EN
        mis_d   = (owner_q == OWN_LS) &&
                  misaligned(size_q, agu_address[1:0]);
`endif
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // last_q resets to LS so the first tie goes to BR
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_BR;
      last_q  <= OWN_LS;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
`ifdef AGU_ARB_MISALIGN_CHECK_EN
      size_q  <= '0;
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
`ifdef AGU_ARB_MISALIGN_CHECK_EN
      size_q  <= size_d;
      mis_q   <= mis_d;
`endif
    end
  end

endmodule

// File: tb/tb_agu_share_arbiter.sv
// Directed bench for agu_share_arbiter: vector table plus corner sequences.
// Runs a round-robin instance and a fixed-priority instance side by side.
module tb_agu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        br_req_valid, ls_req_valid;
  logic [31:0] br_pc, br_imm, ls_base, ls_imm;
  logic [1:0]  ls_size;
  logic        br_rsp_ready, ls_rsp_ready;

  logic        br_req_ready, ls_req_ready;
  logic [31:0] agu_pc, agu_immediate, agu_address;
  logic        br_rsp_valid, ls_rsp_valid;
  logic [31:0] br_rsp_address, ls_rsp_address;

  logic        f_br_req_ready, f_ls_req_ready;
  logic [31:0] f_pc, f_imm, f_address;
  logic        f_br_rsp_valid, f_ls_rsp_valid;
  logic [31:0] f_br_rsp_address, f_ls_rsp_address;

`ifdef AGU_ARB_MISALIGN_CHECK_EN
  logic        ls_rsp_misaligned, f_mis;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign agu_address = agu_pc + agu_immediate;
  assign f_address   = f_pc + f_imm;

  agu_share_arbiter #(.ADDR_WIDTH(32), .FIXED_PRIORITY(0)) dut (
    .clk(clk), .reset(reset),
    .br_req_valid(br_req_valid), .br_req_ready(br_req_ready),
    .br_pc(br_pc), .br_imm(br_imm),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready),
    .ls_base(ls_base), .ls_imm(ls_imm), .ls_size(ls_size),
    .agu_pc(agu_pc), .agu_immediate(agu_immediate),
    .agu_address(agu_address),
    .br_rsp_valid(br_rsp_valid), .br_rsp_ready(br_rsp_ready),
    .br_rsp_address(br_rsp_address),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_ready(ls_rsp_ready),
    .ls_rsp_address(ls_rsp_address)
`ifdef AGU_ARB_MISALIGN_CHECK_EN
    , .ls_rsp_misaligned(ls_rsp_misaligned)
`endif
  );

  agu_share_arbiter #(.ADDR_WIDTH(32), .FIXED_PRIORITY(1)) u_fix (
    .clk(clk), .reset(reset),
    .br_req_valid(br_req_valid), .br_req_ready(f_br_req_ready),
    .br_pc(br_pc), .br_imm(br_imm),
    .ls_req_valid(ls_req_valid), .ls_req_ready(f_ls_req_ready),
    .ls_base(ls_base), .ls_imm(ls_imm), .ls_size(ls_size),
    .agu_pc(f_pc), .agu_immediate(f_imm),
    .agu_address(f_address),
    .br_rsp_valid(f_br_rsp_valid), .br_rsp_ready(br_rsp_ready),
    .br_rsp_address(f_br_rsp_address),
    .ls_rsp_valid(f_ls_rsp_valid), .ls_rsp_ready(ls_rsp_ready),
    .ls_rsp_address(f_ls_rsp_address)
`ifdef AGU_ARB_MISALIGN_CHECK_EN
    , .ls_rsp_misaligned(f_mis)
`endif
  );

  typedef struct {
    logic        br_v;
    logic [31:0] br_pc;
    logic [31:0] br_imm;
    logic        ls_v;
    logic [31:0] ls_base;
    logic [31:0] ls_imm;
    logic [1:0]  sz;
    logic        own;
    logic [31:0] addr;
    logic        mis;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    br_req_valid = 1'b0;
    ls_req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // own: 0=BR, 1=LS (round-robin instance)
    vecs[0] = '{1'b1, 32'h0000_1000, 32'hFFFF_FFF0, 1'b0, 32'h0, 32'h0,
                2'b10, 1'b0, 32'h0000_0FF0, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0010, 32'h0000_0004, 1'b1, 32'h2000_0000,
                32'h0000_0004, 2'b10, 1'b1, 32'h2000_0004, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0100, 32'h0000_0020, 1'b1, 32'h0000_0040,
                32'h0000_0001, 2'b10, 1'b0, 32'h0000_0120, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0200, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC,
                32'h0000_0008, 2'b10, 1'b1, 32'h0000_0004, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0300,
                32'h0000_0003, 2'b00, 1'b0, 32'h0000_0000, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_0400, 32'h0000_0008, 1'b1, 32'h0000_0100,
                32'h0000_0002, 2'b10, 1'b1, 32'h0000_0102, 1'b1};
    vecs[6] = '{1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0100, 32'h0000_0002,
                2'b00, 1'b1, 32'h0000_0102, 1'b0};
    vecs[7] = '{1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0101, 32'h0000_0000,
                2'b01, 1'b1, 32'h0000_0101, 1'b1};
    vecs[8] = '{1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0003, 32'h0000_0001,
                2'b11, 1'b1, 32'h0000_0004, 1'b0};

    reset = 1'b0;
    idle_inputs();
    br_pc = '0; br_imm = '0; ls_base = '0; ls_imm = '0; ls_size = '0;
    br_rsp_ready = 1'b1;
    ls_rsp_ready = 1'b1;

    repeat (2) tick();
    chk("rst_br_rsp_valid", {31'd0, br_rsp_valid}, 32'd0);
    chk("rst_ls_rsp_valid", {31'd0, ls_rsp_valid}, 32'd0);
    chk("rst_agu_pc", agu_pc, 32'd0);
    chk("rst_agu_imm", agu_immediate, 32'd0);
    chk("rst_br_addr", br_rsp_address, 32'd0);
    chk("rst_ls_addr", ls_rsp_address, 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_br_ready", {31'd0, br_req_ready}, 32'd0);
    chk("idle_ls_ready", {31'd0, ls_req_ready}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      br_req_valid = vecs[i].br_v;
      br_pc        = vecs[i].br_pc;
      br_imm       = vecs[i].br_imm;
      ls_req_valid = vecs[i].ls_v;
      ls_base      = vecs[i].ls_base;
      ls_imm       = vecs[i].ls_imm;
      ls_size      = vecs[i].sz;
      #1;
      chk($sformatf("v%0d_br_ready", i), {31'd0, br_req_ready},
          {31'd0, !vecs[i].own});
      chk($sformatf("v%0d_ls_ready", i), {31'd0, ls_req_ready},
          {31'd0, vecs[i].own});
      chk($sformatf("v%0d_fix_br_ready", i), {31'd0, f_br_req_ready},
          {31'd0, vecs[i].br_v});
      chk($sformatf("v%0d_fix_ls_ready", i), {31'd0, f_ls_req_ready},
          {31'd0, !vecs[i].br_v && vecs[i].ls_v});
      tick();
      idle_inputs();
      chk($sformatf("v%0d_busy_ready", i),
          {30'd0, br_req_ready, ls_req_ready}, 32'd0);
      tick();
      chk($sformatf("v%0d_br_rsp_valid", i), {31'd0, br_rsp_valid},
          {31'd0, !vecs[i].own});
      chk($sformatf("v%0d_ls_rsp_valid", i), {31'd0, ls_rsp_valid},
          {31'd0, vecs[i].own});
      chk($sformatf("v%0d_addr", i),
          vecs[i].own ? ls_rsp_address : br_rsp_address, vecs[i].addr);
`ifdef AGU_ARB_MISALIGN_CHECK_EN
      chk($sformatf("v%0d_mis", i), {31'd0, ls_rsp_misaligned},
          {31'd0, vecs[i].own && vecs[i].mis});
`endif
      tick();
    end

    // LS result held under backpressure while BR waits
    ls_req_valid = 1'b1;
    ls_base = 32'h2000_0000;
    ls_imm  = 32'h0000_0004;
    ls_size = 2'b10;
    ls_rsp_ready = 1'b0;
    #1;
    chk("bp_ls_ready", {31'd0, ls_req_ready}, 32'd1);
    tick();
    ls_req_valid = 1'b0;
    br_req_valid = 1'b1;
    br_pc  = 32'h0000_0008;
    br_imm = 32'h0000_0008;
    #1;
    chk("bp_compute_br_ready", {31'd0, br_req_ready}, 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_ls_valid", k), {31'd0, ls_rsp_valid}, 32'd1);
      chk($sformatf("bp%0d_ls_addr", k), ls_rsp_address, 32'h2000_0004);
      chk($sformatf("bp%0d_req_ready", k),
          {30'd0, br_req_ready, ls_req_ready}, 32'd0);
      chk($sformatf("bp%0d_br_valid", k), {31'd0, br_rsp_valid}, 32'd0);
      tick();
    end
    ls_rsp_ready = 1'b1;
    tick();
    chk("bp_after_br_ready", {31'd0, br_req_ready}, 32'd1);
    chk("bp_after_ls_valid", {31'd0, ls_rsp_valid}, 32'd0);
    tick();
    idle_inputs();
    tick();
    chk("bp_br_rsp_valid", {31'd0, br_rsp_valid}, 32'd1);
    chk("bp_br_addr", br_rsp_address, 32'h0000_0010);
    tick();

    // asynchronous reset while an op is in COMPUTE
    br_req_valid = 1'b1;
    ls_req_valid = 1'b1;
    br_pc = 32'h0000_0004; br_imm = 32'h0000_0004;
    ls_base = 32'h0000_0008; ls_imm = 32'h0000_0008;
    tick();
    idle_inputs();
    #1;
    chk("mid_agu_pc_nonzero", {31'd0, agu_pc != 32'd0}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_agu_pc", agu_pc, 32'd0);
    chk("mid_rst_agu_imm", agu_immediate, 32'd0);
    chk("mid_rst_br_valid", {31'd0, br_rsp_valid}, 32'd0);
    chk("mid_rst_ls_valid", {31'd0, ls_rsp_valid}, 32'd0);
    chk("mid_rst_br_addr", br_rsp_address, 32'd0);
    #1;
    reset = 1'b1;
    tick();
    br_req_valid = 1'b1;
    ls_req_valid = 1'b1;
    #1;
    chk("post_rst_br_ready", {31'd0, br_req_ready}, 32'd1);
    chk("post_rst_ls_ready", {31'd0, ls_req_ready}, 32'd0);
    tick();
    idle_inputs();
    tick();
    chk("post_rst_br_valid", {31'd0, br_rsp_valid}, 32'd1);
    chk("post_rst_br_addr", br_rsp_address, 32'h0000_0008);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
